// File: rtl/tex_column_gen.sv
// Texture column generator: walks one ray column, issues texel requests and
// writes ceiling/wall/floor pixels. Optional macro SIDE_SHADE_EN darkens y-side walls.
module tex_column_gen #(
  parameter int          SCREEN_WIDTH  = 320,
  parameter int          SCREEN_HEIGHT = 180,
  parameter int          TEX_LATENCY   = 2,
  parameter logic [15:0] CEIL_COLOR    = 16'h4208,
  parameter logic [15:0] FLOOR_COLOR   = 16'h8410,
  parameter logic [15:0] FLAT_COLOR    = 16'hF800
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        col_valid_in,
  output logic        col_ready_out,
  input  logic [8:0]  col_index_in,
  input  logic [15:0] line_height_in,
  input  logic [15:0] tex_step_in,
  input  logic [15:0] wallX_in,
  input  logic [3:0]  map_val_in,
  input  logic        side_in,
  output logic        tex_req_valid_out,
  output logic [15:0] tex_wallX_out,
  output logic [7:0]  tex_vcount_out,
  output logic [3:0]  tex_id_out,
  input  logic [15:0] tex_pixel_in,
  output logic        fb_we_out,
  output logic [16:0] fb_addr_out,
  output logic [15:0] fb_data_out,
  output logic        col_done_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    C_CEIL,
    C_WALL,
    C_FLOOR
  } cls_t;

  typedef struct packed {
    logic        vld;
    cls_t        cls;
    logic        tex;
    logic        shade;
    logic [16:0] addr;
  } meta_t;

  localparam logic [15:0] H16   = 16'(SCREEN_HEIGHT);
  localparam logic [15:0] HLAST = 16'(SCREEN_HEIGHT - 1);
  localparam logic [7:0]  VMAX  = 8'(SCREEN_HEIGHT - 1);
  localparam logic [8:0]  W9    = 9'(SCREEN_WIDTH);
  localparam logic [16:0] W17   = 17'(SCREEN_WIDTH);
  localparam logic [7:0]  DLAST = 8'(TEX_LATENCY - 1);

  state_t state_q, state_d;

  logic [8:0]  col_q, col_d;
  logic [15:0] lh_q, lh_d;
  logic [15:0] step_q, step_d;
  logic [15:0] wallx_q, wallx_d;
  logic [3:0]  map_q, map_d;
  logic        side_q, side_d;
  logic [15:0] ds_q, ds_d;
  logic [15:0] de_q, de_d;
  logic [15:0] tp_q, tp_d;
  logic [15:0] row_q, row_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  drn_q, drn_d;

  meta_t meta_q [TEX_LATENCY];
  meta_t meta_in;
  meta_t out_m;

  logic        run;
  logic        col_ok;
  logic        is_ceil;
  logic        is_wall;
  logic        tex_map;
  logic        req;
  logic [16:0] sum;
  logic [15:0] tp_inc;
  logic [7:0]  vcount;
  logic [15:0] half;
  logic [15:0] ds_c;
  logic [15:0] de_c;
  logic [15:0] tp_c;
  logic [15:0] pix;

  // State register
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: setup, one row per clock, drain, done pulse
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (col_valid_in) state_d = S_SETUP;
      S_SETUP: state_d = S_RUN;
      S_RUN:   if (row_q == HLAST) state_d = S_DRAIN;
      S_DRAIN: if (drn_q == DLAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    col_ready_out = (state_q == S_IDLE);
    col_done_out  = (state_q == S_DONE);
    run           = (state_q == S_RUN);
  end

  // Wall span and initial texture position for the captured column
  always_comb begin
    half = (lh_q - H16) >> 1;
    ds_c = '0;
    de_c = HLAST;
    tp_c = '0;
    if (lh_q == 16'd0) begin
      ds_c = H16;
    end else if (lh_q < H16) begin
      ds_c = (H16 - lh_q) >> 1;
      de_c = ds_c + lh_q - 16'd1;
    end else begin
      tp_c = half * step_q;
    end
  end

  // Row classification and texture request for the current row
  always_comb begin
    col_ok  = (col_q < W9);
    is_ceil = (row_q < ds_q);
    is_wall = !is_ceil && (row_q <= de_q);
    tex_map = (map_q >= 4'd3) && (map_q <= 4'd5);
    req     = run && col_ok && is_wall && tex_map;
    sum     = {1'b0, tp_q} + {1'b0, step_q};
    tp_inc  = sum[16] ? 16'hFFFF : sum[15:0];
    vcount  = (tp_q[15:8] > VMAX) ? VMAX : tp_q[15:8];
    meta_in       = '0;
    meta_in.vld   = run && col_ok;
    meta_in.cls   = is_ceil ? C_CEIL : (is_wall ? C_WALL : C_FLOOR);
    meta_in.tex   = is_wall && tex_map;
    meta_in.shade = side_q;
    meta_in.addr  = addr_q;
  end

  // Texture request port
  always_comb begin
    tex_req_valid_out = req;
    tex_wallX_out     = req ? wallx_q : '0;
    tex_vcount_out    = req ? vcount : '0;
    tex_id_out        = req ? map_q : '0;
  end

  // Datapath next state: capture, setup, row walk, drain count
  always_comb begin
    col_d   = col_q;
    lh_d    = lh_q;
    step_d  = step_q;
    wallx_d = wallx_q;
    map_d   = map_q;
    side_d  = side_q;
    ds_d    = ds_q;
    de_d    = de_q;
    tp_d    = tp_q;
    row_d   = row_q;
    addr_d  = addr_q;
    drn_d   = drn_q;
    unique case (state_q)
      S_IDLE: begin
        if (col_valid_in) begin
          col_d   = col_index_in;
          lh_d    = line_height_in;
          step_d  = tex_step_in;
          wallx_d = wallX_in;
          map_d   = map_val_in;
          side_d  = side_in;
        end
      end
      S_SETUP: begin
        ds_d   = ds_c;
        de_d   = de_c;
        tp_d   = tp_c;
        row_d  = '0;
        addr_d = {8'b0, col_q};
      end
      S_RUN: begin
        row_d  = row_q + 16'd1;
        addr_d = addr_q + W17;
        drn_d  = '0;
        if (req) tp_d = tp_inc;
      end
      S_DRAIN: begin
        drn_d = drn_q + 8'd1;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      col_q   <= '0;
      lh_q    <= '0;
      step_q  <= '0;
      wallx_q <= '0;
      map_q   <= '0;
      side_q  <= 1'b0;
      ds_q    <= '0;
      de_q    <= '0;
      tp_q    <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      drn_q   <= '0;
    end else begin
      col_q   <= col_d;
      lh_q    <= lh_d;
      step_q  <= step_d;
      wallx_q <= wallx_d;
      map_q   <= map_d;
      side_q  <= side_d;
      ds_q    <= ds_d;
      de_q    <= de_d;
      tp_q    <= tp_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      drn_q   <= drn_d;
    end
  end

  // Row metadata delay line, aligned with texel return
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < TEX_LATENCY; i++) begin
        meta_q[i] <= '0;
      end
    end else begin
      meta_q[0] <= meta_in;
      for (int i = 1; i < TEX_LATENCY; i++) begin
        meta_q[i] <= meta_q[i-1];
      end
    end
  end

  assign out_m = meta_q[TEX_LATENCY-1];

  // Pixel colour select at the pipeline output
  always_comb begin
    pix = '0;
    unique case (1'b1)
      (out_m.cls == C_WALL): pix = out_m.tex ? tex_pixel_in : FLAT_COLOR;
      (out_m.cls == C_CEIL): pix = CEIL_COLOR;
      default:               pix = FLOOR_COLOR;
    endcase
`ifdef SIDE_SHADE_EN
    if ((out_m.cls == C_WALL) && out_m.shade) begin
      pix = {1'b0, pix[15:12], 1'b0, pix[10:6], 1'b0, pix[4:1]};
    end
`endif
    fb_we_out   = out_m.vld;
    fb_addr_out = out_m.vld ? out_m.addr : '0;
    fb_data_out = out_m.vld ? pix : '0;
  end

`ifndef SIDE_SHADE_EN
  logic shade_unused;
  assign shade_unused = out_m.shade;
`endif

endmodule

// File: tb/tb_tex_column_gen.sv
// Bench for tex_column_gen: vector table, random columns vs a row model,
// plus reset-mid-column and back-to-back sequences.
module tb_tex_column_gen;

  localparam int W = 320;
  localparam int H = 180;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        col_valid_in;
  logic        col_ready_out;
  logic [8:0]  col_index_in;
  logic [15:0] line_height_in;
  logic [15:0] tex_step_in;
  logic [15:0] wallX_in;
  logic [3:0]  map_val_in;
  logic        side_in;
  logic        tex_req_valid_out;
  logic [15:0] tex_wallX_out;
  logic [7:0]  tex_vcount_out;
  logic [3:0]  tex_id_out;
  logic [15:0] tex_pix;
  logic        fb_we_out;
  logic [16:0] fb_addr_out;
  logic [15:0] fb_data_out;
  logic        col_done_out;

  always #5 clk = ~clk;

  tex_column_gen dut (
    .pixel_clk_in     (clk),
    .rst_in           (rst_n),
    .col_valid_in     (col_valid_in),
    .col_ready_out    (col_ready_out),
    .col_index_in     (col_index_in),
    .line_height_in   (line_height_in),
    .tex_step_in      (tex_step_in),
    .wallX_in         (wallX_in),
    .map_val_in       (map_val_in),
    .side_in          (side_in),
    .tex_req_valid_out(tex_req_valid_out),
    .tex_wallX_out    (tex_wallX_out),
    .tex_vcount_out   (tex_vcount_out),
    .tex_id_out       (tex_id_out),
    .tex_pixel_in     (tex_pix),
    .fb_we_out        (fb_we_out),
    .fb_addr_out      (fb_addr_out),
    .fb_data_out      (fb_data_out),
    .col_done_out     (col_done_out)
  );

  function automatic logic [15:0] texel(logic [3:0] id, logic [15:0] wx,
                                        logic [7:0] v);
    return {id, 4'h0, v} ^ wx;
  endfunction

  function automatic int halve(int p);
    int r, g, b;
    r = (p >> 11) & 31;
    g = (p >> 5) & 63;
    b = p & 31;
    return ((r / 2) << 11) | ((g / 2) << 5) | (b / 2);
  endfunction

  // Two-clock texture ROM
  logic [15:0] rom_s1;
  always @(posedge clk) begin
    rom_s1  <= tex_req_valid_out ?
               texel(tex_id_out, tex_wallX_out, tex_vcount_out) : 16'hDEAD;
    tex_pix <= rom_s1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int a;
    int d;
    int c;
  } wr_t;

  wr_t wq[$];
  int  rq[$];
  int  dq[$];
  int  done_cnt = 0;

  // Output monitor
  always @(negedge clk) begin
    if (fb_we_out)
      wq.push_back('{a: int'(fb_addr_out), d: int'(fb_data_out), c: cyc});
    if (tex_req_valid_out) rq.push_back(int'(tex_vcount_out));
    if (col_done_out) begin
      dq.push_back(cyc);
      done_cnt++;
    end
  end

  typedef struct {
    int col;
    int lh;
    int step;
    int wx;
    int map;
    int side;
    int nw;
    int caddr;
    int cdata;
  } vec_t;

  int ew_a[$];
  int ew_d[$];
  int ev[$];
  int passed = 0;
  int total = 0;

  task automatic check(string nm, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: per-row colour and texel row from the column rules
  task automatic model(vec_t v);
    int ds, de, pix, vv;
    longint st, pos;
    if (v.col >= W) return;
    st = 0;
    if (v.lh == 0) begin
      ds = H;
      de = -1;
    end else if (v.lh < H) begin
      ds = (H - v.lh) / 2;
      de = ds + v.lh - 1;
    end else begin
      ds = 0;
      de = H - 1;
      st = (longint'((v.lh - H) / 2) * v.step) % 65536;
    end
    for (int r = 0; r < H; r++) begin
      if (r < ds) pix = 16'h4208;
      else if (r <= de) begin
        if (v.map >= 3 && v.map <= 5) begin
          pos = st + longint'(r - ds) * v.step;
          if (pos > 65535) pos = 65535;
          vv = int'(pos / 256);
          if (vv > H - 1) vv = H - 1;
          pix = int'(texel(4'(v.map), 16'(v.wx), 8'(vv)));
          ev.push_back(vv);
        end else pix = 16'hF800;
`ifdef SIDE_SHADE_EN
        if (v.side != 0) pix = halve(pix);
`endif
      end else pix = 16'h8410;
      ew_a.push_back(r * W + v.col);
      ew_d.push_back(pix);
    end
  endtask

  task automatic clear_all();
    wq.delete();
    rq.delete();
    ew_a.delete();
    ew_d.delete();
    ev.delete();
  endtask

  task automatic drive(vec_t v);
    col_index_in   = 9'(v.col);
    line_height_in = 16'(v.lh);
    tex_step_in    = 16'(v.step);
    wallX_in       = 16'(v.wx);
    map_val_in     = 4'(v.map);
    side_in        = v.side[0];
    col_valid_in   = 1'b1;
  endtask

  task automatic wait_accept(output int c);
    c = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (col_ready_out && col_valid_in) begin
        c = cyc;
        break;
      end
    end
    check("accept", c >= 0, 1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done_cnt >= target) break;
    end
    check("done", done_cnt >= target, 1);
  endtask

  task automatic compare_all(string tag, bit chk_req);
    int n;
    check({tag, "_nwr"}, wq.size(), ew_a.size());
    n = (wq.size() < ew_a.size()) ? wq.size() : ew_a.size();
    for (int i = 0; i < n; i++)
      check({tag, "_row"}, longint'(wq[i].a) * 65536 + wq[i].d,
            longint'(ew_a[i]) * 65536 + ew_d[i]);
    if (chk_req) begin
      check({tag, "_nreq"}, rq.size(), ev.size());
      n = (rq.size() < ev.size()) ? rq.size() : ev.size();
      for (int i = 0; i < n; i++) check({tag, "_vcnt"}, rq[i], ev[i]);
    end
  endtask

  task automatic run_vec(vec_t v, string tag);
    int acc, d0, got;
    clear_all();
    model(v);
    d0 = done_cnt;
    @(posedge clk);
    #1 drive(v);
    wait_accept(acc);
    @(posedge clk);
    #1 col_valid_in = 1'b0;
    wait_done(d0 + 1);
    compare_all(tag, v.col < W);
    if (done_cnt > d0) check({tag, "_lat"}, dq[dq.size()-1] - acc, 184);
    if (wq.size() > 0) check({tag, "_first"}, wq[0].c - acc, 4);
    if (v.nw >= 0) check({tag, "_nw"}, wq.size(), v.nw);
    if (v.caddr >= 0) begin
      got = -1;
      foreach (wq[i]) if (wq[i].a == v.caddr) got = wq[i].d;
      check({tag, "_pix"}, got, v.cdata);
    end
  endtask

  vec_t tbl[10];
  vec_t va, vb;
  int   a1, a2, d0, dup;
  bit   seen[int];

  initial begin
    tbl[0] = '{10, 60, 'h0555, 'h00AB, 3, 0, 180, 19210, 'h30AB};
    tbl[1] = '{5, 360, 'h0080, 'h1234, 4, 0, 180, 5, 'h5219};
    tbl[2] = '{100, 100, 'h0100, 0, 1, 0, 180, 12900, 'hF800};
    tbl[3] = '{7, 0, 'h0100, 0, 3, 0, 180, 57287, 'h4208};
    tbl[4] = '{320, 60, 'h0100, 0, 3, 0, 0, -1, 0};
    tbl[5] = '{319, 180, 'h0100, 0, 5, 0, 180, 57599, 'h50B3};
    tbl[6] = '{0, 1, 'h0100, 0, 2, 0, 180, 28480, 'hF800};
    tbl[7] = '{33, 1000, 'hFFFF, 0, 3, 0, 180, 33, 'h30B3};
`ifdef SIDE_SHADE_EN
    tbl[8] = '{2, 100, 'h0100, 0, 1, 1, 180, 16002, 'h7800};
`else
    tbl[8] = '{2, 100, 'h0100, 0, 1, 1, 180, 16002, 'hF800};
`endif
    tbl[9] = '{200, 179, 'h0100, 'h0F0F, 3, 0, 180, 57480, 'h8410};

    rst_n          = 1'b0;
    col_valid_in   = 1'b0;
    col_index_in   = '0;
    line_height_in = '0;
    tex_step_in    = '0;
    wallX_in       = '0;
    map_val_in     = '0;
    side_in        = 1'b0;
    #12;
    check("rst_ready", col_ready_out, 1);
    check("rst_we", fb_we_out, 0);
    check("rst_done", col_done_out, 0);
    check("rst_req", tex_req_valid_out, 0);
    check("rst_addr", fb_addr_out, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      va.col   = $urandom_range(0, 330);
      va.lh    = $urandom_range(0, 400);
      va.step  = $urandom_range(0, 65535);
      va.wx    = $urandom_range(0, 65535);
      va.map   = $urandom_range(0, 15);
      va.side  = $urandom_range(0, 1);
      va.nw    = -1;
      va.caddr = -1;
      va.cdata = 0;
      run_vec(va, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a column
    clear_all();
    va = '{20, 60, 'h0555, 'h0033, 3, 0, 180, -1, 0};
    @(posedge clk);
    #1 drive(va);
    wait_accept(a1);
    @(posedge clk);
    #1 col_valid_in = 1'b0;
    repeat (51) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_we", fb_we_out, 0);
    check("mid_ready", col_ready_out, 1);
    check("mid_req", tex_req_valid_out, 0);
    check("mid_prewr", wq.size() > 40, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_all();
    d0 = done_cnt;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stale_wr", wq.size(), 0);
    check("stale_done", done_cnt, d0);
    va.col = 21;
    run_vec(va, "after_rst");

    // Back-to-back columns with valid held high
    clear_all();
    va = '{30, 90, 'h0200, 'h0101, 3, 0, 180, -1, 0};
    vb = '{31, 200, 'h0100, 0, 1, 0, 180, -1, 0};
    model(va);
    model(vb);
    d0 = done_cnt;
    @(posedge clk);
    #1 drive(va);
    wait_accept(a1);
    @(posedge clk);
    #1 drive(vb);
    wait_accept(a2);
    @(posedge clk);
    #1 col_valid_in = 1'b0;
    wait_done(d0 + 2);
    if (done_cnt >= d0 + 2) check("b2b_gap", a2 - dq[dq.size()-2], 1);
    check("b2b_total", wq.size(), 360);
    dup = 0;
    foreach (wq[i]) begin
      if (seen.exists(wq[i].a)) dup++;
      seen[wq[i].a] = 1'b1;
    end
    check("b2b_overlap", dup, 0);
    compare_all("b2b", 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
